dmi_sba_responder: RTL and testbench
====================================

# dmi_sba_responder

Debug-module-side responder for the 41-bit DMI request stream ({addr[6:0], data[31:0], op[1:0]}) produced by the JTAG DTM on USER4. It decodes DMI reads/writes to a small system-bus-access (SBA) register set, returns one DMI response per accepted request, and runs single-word system bus reads/writes on command. It sits between the DTM and the rv32i memory arbiter, giving JTAG peek/poke access to BRAM.

## Interface
- ADDR_WIDTH, 7, DMI address width
- DATA_WIDTH, 32, DMI and system bus data/address width
- SB_TIMEOUT, 255, max cycles in SB_WAIT before a timeout error (8-bit counter)
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- dmi_req_valid  in  1  request valid
- dmi_req_ready  out  1  request accepted when valid&ready
- dmi_req_addr  in  7  register address
- dmi_req_data  in  32  write data
- dmi_req_op  in  2  0 NOP, 1 RD, 2 WR, 3 reserved (treated as NOP)
- dmi_resp_valid  out  1  response valid, held until ready
- dmi_resp_ready  in  1  response consumed
- dmi_resp_data  out  32  read data (0 for NOP/WR)
- dmi_resp_op  out  2  0 success, 3 busy
- sb_req_valid  out  1  bus request, held until sb_req_ready
- sb_req_ready  in  1  bus accepts request
- sb_req_we  out  1  1 write, 0 read
- sb_req_addr  out  32  byte address (SBADDRESS0)
- sb_req_wdata  out  32  write data (SBDATA0)
- sb_resp_valid  in  1  bus completion strobe
- sb_resp_rdata  in  32  read data, valid with sb_resp_valid
- sb_resp_err  in  1  bus error, valid with sb_resp_valid

## Operation
- Registers: 0x38 SBCS (RD: {29'b0, timeout_err, bus_err, sbbusy}; WR: bit1=1 clears bus_err, bit2=1 clears timeout_err); 0x39 SBADDRESS0 RW; 0x3C SBDATA0 RW; 0x44 SBRD trigger (WR with data[0]=1 starts bus read); 0x48 SBWR trigger (WR with data[0]=1 starts bus write); RD of 0x44/0x48 returns 0. Unmapped addresses: RD returns 0, WR ignored, op 0.
- DMI FSM: D_IDLE (dmi_req_ready=1) -> D_RESP on accept; D_RESP (ready=0, resp_valid=1) -> D_IDLE when dmi_resp_ready.
- sbbusy = bus FSM not in S_IDLE, sampled at accept cycle. While busy: any WR to 0x39/0x3C/0x44/0x48 or RD of 0x3C returns op 3 with no state change; SBCS accesses and NOPs proceed normally.
- Bus FSM: S_IDLE -> S_REQ on trigger; S_REQ drives sb_req_valid with we/addr/wdata frozen -> S_WAIT on sb_req_ready; S_WAIT -> S_IDLE on sb_resp_valid or when timeout counter reaches SB_TIMEOUT (counter cleared entering S_WAIT, counts S_WAIT cycles).
- Completion: read without error loads sb_resp_rdata into SBDATA0; sb_resp_err sets bus_err (SBDATA0 unchanged); timeout sets timeout_err. Sticky flags clear only by SBCS write or reset.
- Trigger with data[0]=0 is a no-op, op 0. Addresses not auto-incremented.

## Timing
- Reset: dmi_req_ready=0 during reset, 1 first cycle after; dmi_resp_valid=0, dmi_resp_data=0, dmi_resp_op=0, sb_req_valid=0, sb_req_we=0, sb_req_addr=0, sb_req_wdata=0; SBADDRESS0=SBDATA0=0, flags=0, FSMs idle.
- Request accepted cycle N -> dmi_resp_valid at N+1; next accept earliest the cycle after resp handshake (1 request per 2 cycles max).
- Register write effective at N+1; RD data is the register value at N.
- Trigger accepted at N -> sb_req_valid at N+1.
- sb_resp_valid at M -> SBDATA0/flags updated and sbbusy=0 at M+1; a DMI request accepted at M sees busy.
- Late sb_resp_valid in S_IDLE/S_REQ ignored.
- Reset mid-transfer: all state returns to reset values next edge; outstanding bus response discarded.

## Test plan
- WR 0x39=0x80001000, RD 0x39 -> resp data 0x80001000 op 0, sb_req_valid stays 0.
- WR 0x3C=0x12345678, WR 0x48=1 -> sb_req we=1 addr 0x80001000 wdata 0x12345678 at N+1; after sb_resp_valid, RD 0x38 -> 0x0.
- WR 0x44=1, bus returns 0xDEADBEEF after 5 cycles -> RD 0x3C = 0xDEADBEEF op 0; RD 0x3C issued during wait -> op 3.
- Bus never responds -> after 255 S_WAIT cycles RD 0x38 = 0x4; WR 0x38=0x4 -> RD 0x38 = 0x0.
- sb_resp_err=1 on read -> SBDATA0 unchanged, RD 0x38 = 0x2; dmi_resp_ready held low 10 cycles -> resp_valid/data stable, req_ready=0 throughout.
- reset_n low during S_WAIT -> all outputs at reset values next cycle; subsequent sb_resp_valid has no effect, RD 0x3C = 0.

Source files
------------

// File: rtl/dmi_sba_responder.sv
// DMI responder for the debug module: decodes DMI reads/writes to a small SBA register set
// and runs single-word system bus reads/writes on command.
module dmi_sba_responder #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SB_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [ADDR_WIDTH-1:0] dmi_req_addr,
    input  logic [DATA_WIDTH-1:0] dmi_req_data,
    input  logic [1:0]            dmi_req_op,
    output logic                  dmi_resp_valid,
    input  logic                  dmi_resp_ready,
    output logic [DATA_WIDTH-1:0] dmi_resp_data,
    output logic [1:0]            dmi_resp_op,
    output logic                  sb_req_valid,
    input  logic                  sb_req_ready,
    output logic                  sb_req_we,
    output logic [DATA_WIDTH-1:0] sb_req_addr,
    output logic [DATA_WIDTH-1:0] sb_req_wdata,
    input  logic                  sb_resp_valid,
    input  logic [DATA_WIDTH-1:0] sb_resp_rdata,
    input  logic                  sb_resp_err
);

    localparam logic [ADDR_WIDTH-1:0] AddrSbcs   = ADDR_WIDTH'(7'h38);
    localparam logic [ADDR_WIDTH-1:0] AddrSbAddr = ADDR_WIDTH'(7'h39);
    localparam logic [ADDR_WIDTH-1:0] AddrSbData = ADDR_WIDTH'(7'h3C);
    localparam logic [ADDR_WIDTH-1:0] AddrSbRd   = ADDR_WIDTH'(7'h44);
    localparam logic [ADDR_WIDTH-1:0] AddrSbWr   = ADDR_WIDTH'(7'h48);

    localparam logic [1:0] OpRd     = 2'd1;
    localparam logic [1:0] OpWr     = 2'd2;
    localparam logic [1:0] RespOk   = 2'd0;
    localparam logic [1:0] RespBusy = 2'd3;

    localparam int unsigned CntW = 8;
    // Timeout fires on the SB_TIMEOUT-th wait cycle; counter holds cycles already spent.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(SB_TIMEOUT - 1);

    typedef enum logic {
        DIdle,
        DResp
    } dmi_state_e;

    typedef enum logic [1:0] {
        SIdle,
        SReq,
        SWait
    } sb_state_e;

    dmi_state_e            dmi_state_q, dmi_state_d;
    sb_state_e             sb_state_q, sb_state_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_op_q, resp_op_d;
    logic [DATA_WIDTH-1:0] sbaddr_q, sbaddr_d;
    logic [DATA_WIDTH-1:0] sbdata_q, sbdata_d;
    logic                  bus_err_q, bus_err_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  sb_we_q, sb_we_d;
    logic [DATA_WIDTH-1:0] sb_addr_q, sb_addr_d;
    logic [DATA_WIDTH-1:0] sb_wdata_q, sb_wdata_d;

    logic                  sb_busy;
    logic                  sbaddr_we;
    logic                  sbdata_we;
    logic                  clr_bus_err;
    logic                  clr_timeout_err;
    logic                  start_rd;
    logic                  start_wr;

    assign sb_busy = (sb_state_q != SIdle);

    // DMI request decode and response FSM
    always_comb begin
        dmi_state_d     = dmi_state_q;
        resp_data_d     = resp_data_q;
        resp_op_d       = resp_op_q;
        sbaddr_we       = 1'b0;
        sbdata_we       = 1'b0;
        clr_bus_err     = 1'b0;
        clr_timeout_err = 1'b0;
        start_rd        = 1'b0;
        start_wr        = 1'b0;

        case (dmi_state_q)
            DIdle: begin
                if (dmi_req_valid) begin
                    dmi_state_d = DResp;
                    resp_data_d = '0;
                    resp_op_d   = RespOk;
                    if (dmi_req_op == OpRd) begin
                        case (dmi_req_addr)
                            AddrSbcs: begin
                                resp_data_d = {{(DATA_WIDTH - 3){1'b0}},
                                               timeout_err_q, bus_err_q, sb_busy};
                            end
                            AddrSbAddr: resp_data_d = sbaddr_q;
                            AddrSbData: begin
                                if (sb_busy) begin
                                    resp_op_d = RespBusy;
                                end else begin
                                    resp_data_d = sbdata_q;
                                end
                            end
                            default: resp_data_d = '0;
                        endcase
                    end else if (dmi_req_op == OpWr) begin
                        case (dmi_req_addr)
                            AddrSbcs: begin
                                clr_bus_err     = dmi_req_data[1];
                                clr_timeout_err = dmi_req_data[2];
                            end
                            AddrSbAddr: begin
                                if (sb_busy) resp_op_d = RespBusy;
                                else sbaddr_we = 1'b1;
                            end
                            AddrSbData: begin
                                if (sb_busy) resp_op_d = RespBusy;
                                else sbdata_we = 1'b1;
                            end
                            AddrSbRd: begin
                                if (sb_busy) resp_op_d = RespBusy;
                                else start_rd = dmi_req_data[0];
                            end
                            AddrSbWr: begin
                                if (sb_busy) resp_op_d = RespBusy;
                                else start_wr = dmi_req_data[0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
            DResp: begin
                if (dmi_resp_ready) begin
                    dmi_state_d = DIdle;
                end
            end
            default: dmi_state_d = DIdle;
        endcase
    end

    // System bus FSM and register updates
    always_comb begin
        sb_state_d    = sb_state_q;
        cnt_d         = cnt_q;
        sb_we_d       = sb_we_q;
        sb_addr_d     = sb_addr_q;
        sb_wdata_d    = sb_wdata_q;
        sbaddr_d      = sbaddr_we ? dmi_req_data : sbaddr_q;
        sbdata_d      = sbdata_we ? dmi_req_data : sbdata_q;
        // Clears apply first so a completion in the same cycle still sets its flag.
        bus_err_d     = bus_err_q & ~clr_bus_err;
        timeout_err_d = timeout_err_q & ~clr_timeout_err;

        case (sb_state_q)
            SIdle: begin
                if (start_rd || start_wr) begin
                    sb_state_d = SReq;
                    sb_we_d    = start_wr;
                    sb_addr_d  = sbaddr_q;
                    sb_wdata_d = sbdata_q;
                end
            end
            SReq: begin
                if (sb_req_ready) begin
                    sb_state_d = SWait;
                    cnt_d      = '0;
                end
            end
            SWait: begin
                if (sb_resp_valid) begin
                    sb_state_d = SIdle;
                    if (sb_resp_err) begin
                        bus_err_d = 1'b1;
                    end else if (!sb_we_q) begin
                        sbdata_d = sb_resp_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    sb_state_d    = SIdle;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: sb_state_d = SIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dmi_state_q   <= DIdle;
            sb_state_q    <= SIdle;
            resp_data_q   <= '0;
            resp_op_q     <= RespOk;
            sbaddr_q      <= '0;
            sbdata_q      <= '0;
            bus_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            sb_we_q       <= 1'b0;
            sb_addr_q     <= '0;
            sb_wdata_q    <= '0;
        end else begin
            dmi_state_q   <= dmi_state_d;
            sb_state_q    <= sb_state_d;
            resp_data_q   <= resp_data_d;
            resp_op_q     <= resp_op_d;
            sbaddr_q      <= sbaddr_d;
            sbdata_q      <= sbdata_d;
            bus_err_q     <= bus_err_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            sb_we_q       <= sb_we_d;
            sb_addr_q     <= sb_addr_d;
            sb_wdata_q    <= sb_wdata_d;
        end
    end

    assign dmi_req_ready  = reset_n && (dmi_state_q == DIdle);
    assign dmi_resp_valid = (dmi_state_q == DResp);
    assign dmi_resp_data  = resp_data_q;
    assign dmi_resp_op    = resp_op_q;
    assign sb_req_valid   = (sb_state_q == SReq);
    assign sb_req_we      = sb_we_q;
    assign sb_req_addr    = sb_addr_q;
    assign sb_req_wdata   = sb_wdata_q;

endmodule

// File: tb/tb_dmi_sba_responder.sv
// Directed bench for dmi_sba_responder: DMI register access, bus read/write, errors, timeout
// and mid-transfer reset.
module tb_dmi_sba_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_op;
    logic        sb_req_valid;
    logic        sb_req_ready;
    logic        sb_req_we;
    logic [31:0] sb_req_addr;
    logic [31:0] sb_req_wdata;
    logic        sb_resp_valid;
    logic [31:0] sb_resp_rdata;
    logic        sb_resp_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        sb_valid_at_resp;
    logic [31:0] rd;
    logic [1:0]  rop;

    always #5 clock = ~clock;

    dmi_sba_responder dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_op    (dmi_resp_op),
        .sb_req_valid   (sb_req_valid),
        .sb_req_ready   (sb_req_ready),
        .sb_req_we      (sb_req_we),
        .sb_req_addr    (sb_req_addr),
        .sb_req_wdata   (sb_req_wdata),
        .sb_resp_valid  (sb_resp_valid),
        .sb_resp_rdata  (sb_resp_rdata),
        .sb_resp_err    (sb_resp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full DMI request/response handshake, all edges aligned to negedge.
    task automatic dmi_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic [1:0] rsp_op);
        int n;
        n = 0;
        @(negedge clock);
        dmi_req_valid = 1'b1;
        dmi_req_op    = op;
        dmi_req_addr  = addr;
        dmi_req_data  = data;
        while (!dmi_req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check_eq("req_ready_wait", 32'(dmi_req_ready), 32'd1);
        @(negedge clock);
        dmi_req_valid    = 1'b0;
        dmi_req_op       = 2'd0;
        sb_valid_at_resp = sb_req_valid;
        check_eq("resp_valid_n1", 32'(dmi_resp_valid), 32'd1);
        rdata          = dmi_resp_data;
        rsp_op         = dmi_resp_op;
        dmi_resp_ready = 1'b1;
        @(negedge clock);
        dmi_resp_ready = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [6:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_op);
        logic [31:0] d;
        logic [1:0]  o;
        dmi_txn(2'd1, addr, 32'd0, d, o);
        check_eq({tag, "_op"}, 32'(o), 32'(exp_op));
        if (exp_op == 2'd0) check_eq({tag, "_data"}, d, exp_data);
    endtask

    task automatic wr_exp(input string tag, input logic [6:0] addr, input logic [31:0] data,
                          input logic [1:0] exp_op);
        logic [31:0] d;
        logic [1:0]  o;
        dmi_txn(2'd2, addr, data, d, o);
        check_eq({tag, "_op"}, 32'(o), 32'(exp_op));
        check_eq({tag, "_data"}, d, 32'd0);
    endtask

    task automatic sb_accept();
        @(negedge clock);
        sb_req_ready = 1'b1;
        @(negedge clock);
        sb_req_ready = 1'b0;
        check_eq("sb_valid_drop", 32'(sb_req_valid), 32'd0);
    endtask

    task automatic sb_respond(input int delay, input logic [31:0] rdata, input logic err);
        repeat (delay) @(negedge clock);
        sb_resp_valid = 1'b1;
        sb_resp_rdata = rdata;
        sb_resp_err   = err;
        @(negedge clock);
        sb_resp_valid = 1'b0;
        sb_resp_err   = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        dmi_req_valid  = 1'b0;
        dmi_req_addr   = '0;
        dmi_req_data   = '0;
        dmi_req_op     = '0;
        dmi_resp_ready = 1'b0;
        sb_req_ready   = 1'b0;
        sb_resp_valid  = 1'b0;
        sb_resp_rdata  = '0;
        sb_resp_err    = 1'b0;

        repeat (3) @(negedge clock);
        check_eq("rst_req_ready", 32'(dmi_req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        check_eq("rst_resp_data", dmi_resp_data, 32'd0);
        check_eq("rst_resp_op", 32'(dmi_resp_op), 32'd0);
        check_eq("rst_sb_valid", 32'(sb_req_valid), 32'd0);
        check_eq("rst_sb_addr", sb_req_addr, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("post_rst_ready", 32'(dmi_req_ready), 32'd1);

        // Plain register access
        wr_exp("wr_addr", 7'h39, 32'h8000_1000, 2'd0);
        check_eq("wr_addr_no_sb", 32'(sb_valid_at_resp), 32'd0);
        rd_exp("rd_addr", 7'h39, 32'h8000_1000, 2'd0);
        check_eq("rd_addr_no_sb", 32'(sb_req_valid), 32'd0);
        rd_exp("rd_unmapped", 7'h10, 32'd0, 2'd0);
        wr_exp("wr_unmapped", 7'h11, 32'hFFFF_FFFF, 2'd0);
        wr_exp("trig_zero", 7'h44, 32'd0, 2'd0);
        check_eq("trig_zero_no_sb", 32'(sb_req_valid), 32'd0);
        rd_exp("rd_trig", 7'h44, 32'd0, 2'd0);
        dmi_txn(2'd0, 7'h39, 32'h0, rd, rop);
        check_eq("nop_data", rd, 32'd0);

        // Bus write
        wr_exp("wr_data", 7'h3C, 32'h1234_5678, 2'd0);
        wr_exp("trig_wr", 7'h48, 32'd1, 2'd0);
        check_eq("sbw_valid_n1", 32'(sb_valid_at_resp), 32'd1);
        check_eq("sbw_valid_held", 32'(sb_req_valid), 32'd1);
        check_eq("sbw_we", 32'(sb_req_we), 32'd1);
        check_eq("sbw_addr", sb_req_addr, 32'h8000_1000);
        check_eq("sbw_wdata", sb_req_wdata, 32'h1234_5678);
        rd_exp("sbcs_busy_req", 7'h38, 32'h1, 2'd0);
        sb_accept();
        sb_respond(2, 32'hAAAA_AAAA, 1'b0);
        rd_exp("sbcs_after_wr", 7'h38, 32'h0, 2'd0);
        rd_exp("data_after_wr", 7'h3C, 32'h1234_5678, 2'd0);

        // Bus read with busy-blocked accesses during the wait
        wr_exp("trig_rd", 7'h44, 32'd1, 2'd0);
        check_eq("sbr_we", 32'(sb_req_we), 32'd0);
        check_eq("sbr_addr", sb_req_addr, 32'h8000_1000);
        sb_accept();
        rd_exp("rd_data_busy", 7'h3C, 32'd0, 2'd3);
        wr_exp("wr_addr_busy", 7'h39, 32'h0000_FFFF, 2'd3);
        sb_respond(0, 32'hDEAD_BEEF, 1'b0);
        rd_exp("rd_data_done", 7'h3C, 32'hDEAD_BEEF, 2'd0);
        rd_exp("addr_kept", 7'h39, 32'h8000_1000, 2'd0);

        // Timeout
        wr_exp("trig_rd_to", 7'h44, 32'd1, 2'd0);
        sb_accept();
        rd_exp("sbcs_wait", 7'h38, 32'h1, 2'd0);
        repeat (300) @(negedge clock);
        rd_exp("sbcs_timeout", 7'h38, 32'h4, 2'd0);
        check_eq("to_sb_idle", 32'(sb_req_valid), 32'd0);
        wr_exp("clr_to", 7'h38, 32'h4, 2'd0);
        rd_exp("sbcs_to_clr", 7'h38, 32'h0, 2'd0);

        // Bus error plus stalled response
        wr_exp("trig_rd_err", 7'h44, 32'd1, 2'd0);
        sb_accept();
        sb_respond(1, 32'h5555_5555, 1'b1);
        rd_exp("data_after_err", 7'h3C, 32'hDEAD_BEEF, 2'd0);
        @(negedge clock);
        check_eq("hold_pre_ready", 32'(dmi_req_ready), 32'd1);
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd1;
        dmi_req_addr  = 7'h38;
        @(negedge clock);
        dmi_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_valid", 32'(dmi_resp_valid), 32'd1);
            check_eq("hold_data", dmi_resp_data, 32'h2);
            check_eq("hold_op", 32'(dmi_resp_op), 32'd0);
            check_eq("hold_req_ready", 32'(dmi_req_ready), 32'd0);
            @(negedge clock);
        end
        dmi_resp_ready = 1'b1;
        @(negedge clock);
        dmi_resp_ready = 1'b0;
        check_eq("hold_released", 32'(dmi_resp_valid), 32'd0);
        wr_exp("clr_err", 7'h38, 32'h2, 2'd0);
        rd_exp("sbcs_err_clr", 7'h38, 32'h0, 2'd0);

        // Reset during the wait state
        wr_exp("trig_rd_rst", 7'h44, 32'd1, 2'd0);
        sb_accept();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_req_ready", 32'(dmi_req_ready), 32'd0);
        check_eq("mid_rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        check_eq("mid_rst_sb_valid", 32'(sb_req_valid), 32'd0);
        check_eq("mid_rst_sb_we", 32'(sb_req_we), 32'd0);
        check_eq("mid_rst_sb_addr", sb_req_addr, 32'd0);
        check_eq("mid_rst_sb_wdata", sb_req_wdata, 32'd0);
        reset_n = 1'b1;
        sb_respond(1, 32'hBAD0_BAD0, 1'b0);
        rd_exp("rst_data", 7'h3C, 32'd0, 2'd0);
        rd_exp("rst_addr", 7'h39, 32'd0, 2'd0);
        rd_exp("rst_sbcs", 7'h38, 32'd0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
